// File: rtl/pdm_delay_sum_beamformer.sv
// Delay-and-sum beamformer for 1-bit PDM microphone arrays: per-channel programmable
// steering delay, bipolar summation, accumulate-and-dump decimation and an MSB-first serial copy.
module pdm_delay_sum_beamformer #(
  parameter int N_CH     = 16,
  parameter int DELAY_W  = 4,
  parameter int DEC_LOG2 = 6,
  parameter int OUT_W    = 16,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         pdm_in,
  input  logic                    pdm_stb,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [DELAY_W-1:0]      cfg_delay,
  output logic                    pcm_valid,
  output logic signed [OUT_W-1:0] pcm_data,
  output logic                    ser_out,
  output logic                    ser_frame,
  output logic                    overrun
);

  localparam int CH_LOG2 = $clog2(N_CH);
  localparam int ACC_W   = CH_LOG2 + DEC_LOG2 + 1;
  localparam int TAP_W   = 2 ** DELAY_W;
  localparam int HIST_W  = TAP_W - 1;
  localparam int ONES_W  = CH_LOG2 + 1;
  localparam int SUM_W   = CH_LOG2 + 2;
  localparam int CNT_W   = $clog2(OUT_W + 1);

  if (ACC_W > OUT_W) begin : g_chk_width
    $error("pdm_delay_sum_beamformer: ACC_W exceeds OUT_W");
  end
  if ((N_CH < 2) || (N_CH > 64) || ((N_CH & (N_CH - 1)) != 0)) begin : g_chk_nch
    $error("pdm_delay_sum_beamformer: N_CH must be a power of two in 2..64");
  end

  logic [HIST_W-1:0]  hist    [N_CH];
  logic [DELAY_W-1:0] dly     [N_CH];
  logic [DELAY_W-1:0] dly_eff [N_CH];
  logic [TAP_W-1:0]   tap     [N_CH];
  logic [N_CH-1:0]    sel;
  logic [ONES_W-1:0]  ones;
  logic signed [SUM_W-1:0] s_comb;

  logic signed [SUM_W-1:0] s_q;
  logic                    s_vld;
  logic                    s_last;
  logic [DEC_LOG2-1:0]     fcnt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0]        acc_sat;
  logic [ACC_W-1:0]        dump_q;
  logic                    dump_vld;

  logic [OUT_W-1:0] sh_reg;
  logic [CNT_W-1:0] sh_cnt;

  // A write in the same cycle as a strobe bypasses the delay register.
  always_comb begin
    sel = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      dly_eff[ch] = (cfg_we && (cfg_ch == CH_W'(ch))) ? cfg_delay : dly[ch];
      tap[ch]     = {hist[ch], pdm_in[ch]};
      sel[ch]     = tap[ch][dly_eff[ch]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        hist[ch] <= '0;
        dly[ch]  <= '0;
      end
    end else begin
      if (pdm_stb) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          hist[ch] <= tap[ch][HIST_W-1:0];
        end
      end
      if (cfg_we) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (cfg_ch == CH_W'(ch)) begin
            dly[ch] <= cfg_delay;
          end
        end
      end
    end
  end

  always_comb begin
    ones = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      ones = ones + ONES_W'(sel[ch]);
    end
  end

  assign s_comb = {ones, 1'b0} - SUM_W'(N_CH);

  // Frame counter runs down from all-ones; terminal count 0 marks the frame's last strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt   <= '1;
      s_q    <= '0;
      s_vld  <= 1'b0;
      s_last <= 1'b0;
    end else begin
      s_vld <= pdm_stb;
      if (pdm_stb) begin
        s_q    <= s_comb;
        s_last <= (fcnt == '0);
        fcnt   <= fcnt - DEC_LOG2'(1);
      end
    end
  end

  assign acc_sum = (ACC_W + 1)'(acc) + (ACC_W + 1)'(s_q);

  always_comb begin
    acc_sat = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_sat = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      dump_q   <= '0;
      dump_vld <= 1'b0;
    end else begin
      dump_vld <= s_vld && s_last;
      if (s_vld) begin
        if (s_last) begin
          dump_q <= acc_sat;
          acc    <= '0;
        end else begin
          acc <= acc_sum[ACC_W-1:0];
        end
      end
    end
  end

  // Output word register and serializer; a reload while bits remain is an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_valid <= 1'b0;
      pcm_data  <= '0;
      sh_reg    <= '0;
      sh_cnt    <= '0;
      overrun   <= 1'b0;
    end else begin
      pcm_valid <= dump_vld;
      if (dump_vld) begin
        pcm_data <= OUT_W'(dump_q) << (OUT_W - ACC_W);
      end
      if (pcm_valid) begin
        sh_reg <= pcm_data;
        sh_cnt <= CNT_W'(OUT_W);
        if (sh_cnt != '0) begin
          overrun <= 1'b1;
        end
      end else if (sh_cnt != '0) begin
        sh_reg <= {sh_reg[OUT_W-2:0], 1'b0};
        sh_cnt <= sh_cnt - CNT_W'(1);
      end
    end
  end

  assign ser_out   = (sh_cnt != '0) & sh_reg[OUT_W-1];
  assign ser_frame = (sh_cnt == CNT_W'(OUT_W));

endmodule

// File: tb/tb_pdm_delay_sum_beamformer.sv
// Directed bench for pdm_delay_sum_beamformer: default build plus a DEC_LOG2=3 build
// used to exercise the overrun flag.
module tb_pdm_delay_sum_beamformer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] pdm_in;
  logic        pdm_stb;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [3:0]  cfg_delay;
  logic        pcm_valid;
  logic [15:0] pcm_data;
  logic        ser_out;
  logic        ser_frame;
  logic        overrun;

  logic [15:0] pdm_in2;
  logic        pdm_stb2;
  logic        cfg_we2;
  logic [3:0]  cfg_ch2;
  logic [3:0]  cfg_delay2;
  logic        pcm_valid2;
  logic [15:0] pcm_data2;
  logic        ser_out2;
  logic        ser_frame2;
  logic        overrun2;

  pdm_delay_sum_beamformer #(.N_CH(16), .DELAY_W(4), .DEC_LOG2(6), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pdm_in(pdm_in), .pdm_stb(pdm_stb),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .pcm_valid(pcm_valid), .pcm_data(pcm_data), .ser_out(ser_out),
    .ser_frame(ser_frame), .overrun(overrun)
  );

  pdm_delay_sum_beamformer #(.N_CH(16), .DELAY_W(4), .DEC_LOG2(3), .OUT_W(16)) dut_ov (
    .clk(clk), .rst_n(rst_n), .pdm_in(pdm_in2), .pdm_stb(pdm_stb2),
    .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_delay(cfg_delay2),
    .pcm_valid(pcm_valid2), .pcm_data(pcm_data2), .ser_out(ser_out2),
    .ser_frame(ser_frame2), .overrun(overrun2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives n strobes of pattern p; with gap set, every strobe is preceded by an idle
  // cycle carrying the inverted pattern, which must have no effect.
  task automatic strobes(input logic [15:0] p, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        @(negedge clk);
        pdm_stb = 1'b0;
        pdm_in  = ~p;
        cfg_we  = 1'b0;
      end
      @(negedge clk);
      pdm_stb = 1'b1;
      pdm_in  = p;
      cfg_we  = 1'b0;
    end
    @(negedge clk);
    pdm_stb = 1'b0;
  endtask

  // Called at the negedge just after the frame's last strobe was sampled.
  task automatic expect_word(input string tag, input logic [15:0] w);
    logic [15:0] obs;
    logic [15:0] frm;
    check({tag, "_vld_e0"}, {31'd0, pcm_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_vld_e1"}, {31'd0, pcm_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_vld_e2"}, {31'd0, pcm_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, pcm_data}, {16'd0, w});
    obs = '0;
    frm = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      obs = {obs[14:0], ser_out};
      frm = {frm[14:0], ser_frame};
    end
    check({tag, "_serial"}, {16'd0, obs}, {16'd0, w});
    check({tag, "_frame"}, {16'd0, frm}, 32'h0000_8000);
    @(negedge clk);
    check({tag, "_idle"}, {31'd0, ser_out}, 32'd0);
    check({tag, "_hold"}, {16'd0, pcm_data}, {16'd0, w});
  endtask

  initial begin
    int k;
    pdm_in = '0; pdm_stb = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0;
    pdm_in2 = '0; pdm_stb2 = 1'b0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_delay2 = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, pcm_valid}, 32'd0);
    check("rst_data", {16'd0, pcm_data}, 32'd0);
    check("rst_ser", {31'd0, ser_out}, 32'd0);
    check("rst_frame", {31'd0, ser_frame}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_overrun2", {31'd0, overrun2}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // +1024 saturates to 1023 -> 0x7FE0
    strobes(16'hFFFF, 64, 1'b0);
    expect_word("ones", 16'h7FE0);
    check("ones_overrun", {31'd0, overrun}, 32'd0);

    // -1024 is representable -> 0x8000; gaps must not advance anything
    strobes(16'h0000, 64, 1'b1);
    expect_word("zeros_gap", 16'h8000);
    check("zeros_overrun", {31'd0, overrun}, 32'd0);

    strobes(16'h00FF, 64, 1'b0);
    expect_word("balanced", 16'h0000);

    // Clear history, then steer ch0 by 15 with the write coinciding with strobe 0:
    // 15 strobes at S=0, 49 at S=+2 -> 98<<5
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_delay = 4'd15;
    pdm_stb = 1'b1; pdm_in = 16'h01FF;
    strobes(16'h01FF, 63, 1'b0);
    expect_word("delay", 16'h0C40);

    // Reset mid-frame with a negative partial sum pending; outputs clear asynchronously
    strobes(16'h0000, 30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", {16'd0, pcm_data}, 32'd0);
    check("mid_rst_valid", {31'd0, pcm_valid}, 32'd0);
    check("mid_rst_ser", {31'd0, ser_out}, 32'd0);
    check("mid_rst_frame", {31'd0, ser_frame}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    strobes(16'hFFFF, 64, 1'b0);
    expect_word("post_rst", 16'h7FE0);

    // DEC_LOG2=3 build, strobe every cycle: a word every 8 clocks, 16 clocks to serialise
    @(negedge clk);
    pdm_in2 = 16'hFFFF; pdm_stb2 = 1'b1;
    k = 0;
    while (!pcm_valid2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ov_first_seen", {31'd0, pcm_valid2}, 32'd1);
    check("ov_first_data", {16'd0, pcm_data2}, 32'h0000_7F00);
    check("ov_first_flag", {31'd0, overrun2}, 32'd0);
    @(negedge clk);
    check("ov_msb_frame", {31'd0, ser_frame2}, 32'd1);
    check("ov_msb_bit", {31'd0, ser_out2}, 32'd0);
    check("ov_msb_flag", {31'd0, overrun2}, 32'd0);
    k = 1;
    while (!pcm_valid2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ov_period", k, 32'd8);
    check("ov_second_flag", {31'd0, overrun2}, 32'd0);
    @(negedge clk);
    check("ov_set", {31'd0, overrun2}, 32'd1);
    check("ov_reload_frame", {31'd0, ser_frame2}, 32'd1);
    repeat (30) @(negedge clk);
    check("ov_sticky", {31'd0, overrun2}, 32'd1);
    pdm_stb2 = 1'b0;
    check("main_overrun_final", {31'd0, overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
